// File: rtl/dma_req_credit.sv
// DMA request credit counter: counts request pulses and replays them one at a
// time over valid/ready. Optional request timeout enabled by DMA_REQ_TIMEOUT_EN.
module dma_req_credit #(
  parameter int CW             = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk_b,
  input  logic          reset,
  input  logic          pulse_in,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [CW-1:0] credit_count,
  output logic          overflow,
  input  logic          clear_ovf,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_credit;
  logic          r_ovf;
  logic [7:0]    r_gap;
  logic          w_accept;
  logic          w_expire;
  logic          w_full;
  logic          w_inc;
  logic          w_dec;

  assign w_accept = (r_state == S_REQ) & req_ready;
  assign w_full   = (r_credit == CMAX);
  assign w_dec    = w_accept | w_expire;
  // A pulse at full credit still counts when this cycle frees a slot.
  assign w_inc    = pulse_in & (~w_full | w_dec);

`ifdef DMA_REQ_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  // Accept wins over a coincident expiry.
  assign w_expire = (r_state == S_REQ) & ~req_ready & (r_to_cnt == TO_LAST);

  // Wait counter: runs only while a request sits unaccepted, restarts otherwise.
  always_ff @(posedge clk_b) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if ((r_state == S_REQ) && !req_ready && !w_expire) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Credit counter: +1 per pulse, -1 per accept or abandoned request.
  always_ff @(posedge clk_b) begin
    if (reset) begin
      r_credit <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_credit <= r_credit + CONE;
        2'b01:   r_credit <= r_credit - CONE;
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Sticky overflow flag; clear beats a same-cycle set.
  always_ff @(posedge clk_b) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end else if (pulse_in && w_full && !w_dec) begin
      r_ovf <= 1'b1;
    end
  end

  // Gap counter counts cycles spent in GAP.
  always_ff @(posedge clk_b) begin
    if (reset || (r_state != S_GAP)) begin
      r_gap <= 8'd0;
    end else begin
      r_gap <= r_gap + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_b) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_credit != '0) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_accept) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
          end else if (r_credit > CONE) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = (r_credit != '0) ? S_REQ : S_IDLE;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_valid    = (r_state == S_REQ);
  assign credit_count = r_credit;
  assign overflow     = r_ovf;
  assign busy         = (r_state != S_IDLE) | (r_credit != '0);

endmodule

// File: tb/tb_dma_req_credit.sv
// Directed self-checking bench for dma_req_credit: three instances cover the
// default build, a 2-bit credit counter and a 3-cycle gap.
module tb_dma_req_credit;

  logic clk_b = 1'b0;
  logic reset;
  always #5 clk_b = ~clk_b;

  logic       pulse_a, ready_a, clr_a, valid_a, ovf_a, busy_a, to_a;
  logic [3:0] cnt_a;
  logic       pulse_b, ready_b, clr_b, valid_b, ovf_b, busy_b, to_b;
  logic [1:0] cnt_b;
  logic       pulse_c, ready_c, clr_c, valid_c, ovf_c, busy_c, to_c;
  logic [3:0] cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  dma_req_credit #(.CW(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_b(clk_b), .reset(reset), .pulse_in(pulse_a), .req_valid(valid_a),
    .req_ready(ready_a), .credit_count(cnt_a), .overflow(ovf_a),
    .clear_ovf(clr_a), .busy(busy_a), .timeout(to_a));

  dma_req_credit #(.CW(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(256)) dut_b (
    .clk_b(clk_b), .reset(reset), .pulse_in(pulse_b), .req_valid(valid_b),
    .req_ready(ready_b), .credit_count(cnt_b), .overflow(ovf_b),
    .clear_ovf(clr_b), .busy(busy_b), .timeout(to_b));

  dma_req_credit #(.CW(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(256)) dut_c (
    .clk_b(clk_b), .reset(reset), .pulse_in(pulse_c), .req_valid(valid_c),
    .req_ready(ready_c), .credit_count(cnt_c), .overflow(ovf_c),
    .clear_ovf(clr_c), .busy(busy_c), .timeout(to_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {pulse_a, ready_a, clr_a} = 3'b000;
    {pulse_b, ready_b, clr_b} = 3'b000;
    {pulse_c, ready_c, clr_c} = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int first_acc, second_acc, n_acc, n_wait;

    // Reset state
    do_reset();
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_cnt",   32'(cnt_a),   32'd0);
    check_eq("rst_ovf",   32'(ovf_a),   32'd0);
    check_eq("rst_to",    32'(to_a),    32'd0);
    check_eq("rst_busy",  32'(busy_a),  32'd0);

    // 1: single pulse latency
    ready_a = 1'b1;
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    check_eq("t1_cnt_n1",   32'(cnt_a),   32'd1);
    check_eq("t1_valid_n1", 32'(valid_a), 32'd0);
    tick();
    check_eq("t1_valid_n2", 32'(valid_a), 32'd1);
    tick();
    check_eq("t1_cnt_n3",   32'(cnt_a),   32'd0);
    check_eq("t1_valid_n3", 32'(valid_a), 32'd0);
    check_eq("t1_busy_n3",  32'(busy_a),  32'd0);

    // 2: burst of 5 while stalled, then 5 back-to-back accepts
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse_a = 1'b1;
      tick();
    end
    pulse_a = 1'b0;
    check_eq("t2_cnt5",   32'(cnt_a),   32'd5);
    check_eq("t2_valid",  32'(valid_a), 32'd1);
    ready_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_b2b_valid", 32'(valid_a), 32'd1);
      tick();
      check_eq("t2_b2b_cnt", 32'(cnt_a), 32'(4 - i));
    end
    check_eq("t2_idle_valid", 32'(valid_a), 32'd0);
    tick();
    check_eq("t2_idle_busy", 32'(busy_a), 32'd0);

    // 3: CW=2 overflow and clear
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_b = 1'b1;
      tick();
    end
    pulse_b = 1'b0;
    check_eq("t3_cnt_full", 32'(cnt_b), 32'd3);
    check_eq("t3_ovf_set",  32'(ovf_b), 32'd1);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    check_eq("t3_ovf_clr", 32'(ovf_b), 32'd0);
    check_eq("t3_cnt_kept", 32'(cnt_b), 32'd3);
    pulse_b = 1'b1;
    clr_b   = 1'b1;
    tick();
    clr_b   = 1'b0;
    pulse_b = 1'b0;
    check_eq("t3_clr_prio", 32'(ovf_b), 32'd0);
    pulse_b = 1'b1;
    ready_b = 1'b1;
    tick();
    pulse_b = 1'b0;
    ready_b = 1'b0;
    check_eq("t3_full_acc_cnt", 32'(cnt_b), 32'd3);
    check_eq("t3_full_acc_ovf", 32'(ovf_b), 32'd0);

    // 4: pulse coincident with accept at 2 credits
    do_reset();
    pulse_a = 1'b1;
    tick();
    tick();
    pulse_a = 1'b0;
    check_eq("t4_cnt2",  32'(cnt_a),   32'd2);
    check_eq("t4_valid", 32'(valid_a), 32'd1);
    pulse_a = 1'b1;
    ready_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    ready_a = 1'b0;
    check_eq("t4_cnt_net0", 32'(cnt_a), 32'd2);

    // 5: gap of 3 cycles between accepts
    do_reset();
    ready_c = 1'b1;
    pulse_c = 1'b1;
    tick();
    tick();
    pulse_c = 1'b0;
    first_acc = -1;
    second_acc = -1;
    n_acc = 0;
    for (int i = 0; i < 14; i++) begin
      if (valid_c && ready_c) begin
        if (n_acc == 0) first_acc = i;
        else second_acc = i;
        n_acc++;
      end
      tick();
    end
    check_eq("t5_n_acc", 32'(n_acc), 32'd2);
    check_eq("t5_spacing", 32'(second_acc - first_acc), 32'd4);
    check_eq("t5_cnt_end", 32'(cnt_c), 32'd0);

    // 6: timeout behaviour
    do_reset();
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    tick();
`ifdef DMA_REQ_TIMEOUT_EN
    n_wait = 0;
    while (valid_a && n_wait < 20) begin
      check_eq("t6_to_early", 32'(to_a), 32'd0);
      n_wait++;
      tick();
    end
    check_eq("t6_req_cycles", 32'(n_wait), 32'd8);
    check_eq("t6_to_pulse",   32'(to_a),   32'd1);
    check_eq("t6_cnt",        32'(cnt_a),  32'd0);
    tick();
    check_eq("t6_to_clear",   32'(to_a),   32'd0);
    check_eq("t6_busy",       32'(busy_a), 32'd0);
`else
    n_wait = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!valid_a || to_a) n_wait++;
      tick();
    end
    check_eq("t6_drops",  32'(n_wait),  32'd0);
    check_eq("t6_valid",  32'(valid_a), 32'd1);
    check_eq("t6_cnt",    32'(cnt_a),   32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
